// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 32x64 register file.
// Shares the single write port between the ALU writeback (req0) and the load writeback (req1)
// with round-robin arbitration. After reset, or on init_req_i, it sweeps zero into every
// register. Writes to x0 are discarded. All register-file drive signals come straight from
// flops.
// Optional build macro: REGARB_STALL_CNT_EN adds a 16-bit saturating stall counter on
// stall_count_o. Without it, stall_count_o is tied to zero.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init_req_i,
    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_rd_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_rd_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ready_o,
    output logic [ADDR_W-1:0] rf_write_reg_o,
    output logic [DATA_W-1:0] rf_write_data_o,
    output logic              rf_reg_write_o,
    output logic              init_busy_o,
    output logic [15:0]       stall_count_o
);

    // The sweep index must be able to address every register it clears.
    if (NUM_REGS > (1 << ADDR_W) || NUM_REGS == 0) begin : gen_param_check
        $error("NUM_REGS must be in 1..2**ADDR_W");
    end

    localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
    // 0: req0 was granted last, 1: req1 was granted last.
    logic              last_grant_q, last_grant_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_reg_q, rf_reg_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    logic              arb_en;
    logic              grant0;
    logic              grant1;

    // Round-robin grant; only valid bits and history matter, never rd or data.
    always_comb begin
        arb_en = (state_q == StRun) && !init_req_i;
        grant0 = arb_en && req0_valid_i && (!req1_valid_i || last_grant_q);
        grant1 = arb_en && req1_valid_i && (!req0_valid_i || !last_grant_q);
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    // Next-state: sweep sequencing, accepted-transfer capture and the x0 filter.
    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        last_grant_d = last_grant_q;
        rf_we_d      = 1'b0;
        rf_reg_d     = rf_reg_q;
        rf_data_d    = rf_data_q;

        unique case (state_q)
            StInit: begin
                rf_we_d   = 1'b1;
                rf_reg_d  = init_ptr_q;
                rf_data_d = '0;
                if (init_ptr_q == LastPtr) begin
                    state_d    = StRun;
                    init_ptr_d = '0;
                end else begin
                    init_ptr_d = init_ptr_q + 1'b1;
                end
            end
            StRun: begin
                if (init_req_i) begin
                    state_d    = StInit;
                    init_ptr_d = '0;
                end else if (grant0) begin
                    // rd=0 still completes the handshake but never strobes the file.
                    rf_we_d      = (req0_rd_i != '0);
                    rf_reg_d     = req0_rd_i;
                    rf_data_d    = req0_data_i;
                    last_grant_d = 1'b0;
                end else if (grant1) begin
                    rf_we_d      = (req1_rd_i != '0);
                    rf_reg_d     = req1_rd_i;
                    rf_data_d    = req1_data_i;
                    last_grant_d = 1'b1;
                end
            end
            default: begin
                state_d    = StInit;
                init_ptr_d = '0;
            end
        endcase
    end

    // State and register-file drive flops; reset kills any in-flight write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StInit;
            init_ptr_q   <= '0;
            last_grant_q <= 1'b1;
            rf_we_q      <= 1'b0;
            rf_reg_q     <= '0;
            rf_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_reg_q     <= rf_reg_d;
            rf_data_q    <= rf_data_d;
        end
    end

    assign rf_reg_write_o  = rf_we_q;
    assign rf_write_reg_o  = rf_reg_q;
    assign rf_write_data_o = rf_data_q;
    assign init_busy_o     = (state_q == StInit);

`ifdef REGARB_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;
    logic        stall_event;

    // A stall is any RUN cycle where some requester is waiting without a grant.
    always_comb begin
        stall_event = (state_q == StRun) &&
                      ((req0_valid_i && !grant0) || (req1_valid_i && !grant1));
        stall_d     = stall_q;
        if ((state_q == StRun) && init_req_i) begin
            stall_d = '0;
        end else if (stall_event && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Saturating stall counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count_o = stall_q;
`else
    assign stall_count_o = '0;
`endif

`ifndef SYNTHESIS
    // Never grant both requesters in one cycle.
    assert property (@(posedge clock) disable iff (!reset) !(req0_ready_o && req1_ready_o));
    // Nothing is accepted while the sweep runs.
    assert property (@(posedge clock) disable iff (!reset)
                     init_busy_o |-> !(req0_ready_o || req1_ready_o));
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table for RUN-mode arbitration plus
// hand sequences for the reset sweep, init_req restart, stall counting and mid-sweep reset.
module tb_regfile_write_arbiter;

    logic        clock;
    logic        reset;
    logic        init_req;
    logic        v0, v1;
    logic [4:0]  rd0, rd1;
    logic [63:0] d0, d1;
    logic        r0, r1;
    logic [4:0]  wreg;
    logic [63:0] wdata;
    logic        we;
    logic        busy;
    logic [15:0] stall;

    int n_cmp = 0;
    int n_err = 0;

`ifdef REGARB_STALL_CNT_EN
    localparam bit StallEn = 1'b1;
`else
    localparam bit StallEn = 1'b0;
`endif

    regfile_write_arbiter #(
        .DATA_W  (64),
        .ADDR_W  (5),
        .NUM_REGS(32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .init_req_i     (init_req),
        .req0_valid_i   (v0),
        .req0_rd_i      (rd0),
        .req0_data_i    (d0),
        .req0_ready_o   (r0),
        .req1_valid_i   (v1),
        .req1_rd_i      (rd1),
        .req1_data_i    (d1),
        .req1_ready_o   (r1),
        .rf_write_reg_o (wreg),
        .rf_write_data_o(wdata),
        .rf_reg_write_o (we),
        .init_busy_o    (busy),
        .stall_count_o  (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        v0;
        logic [4:0]  rd0;
        logic [63:0] d0;
        logic        v1;
        logic [4:0]  rd1;
        logic [63:0] d1;
        logic        r0;
        logic        r1;
        logic        we;
        logic [4:0]  wreg;
        logic [63:0] wdata;
        logic [15:0] stall;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] exp_stall(input int unsigned n);
        return StallEn ? 16'(n) : 16'd0;
    endfunction

    initial begin
        // v0 rd0 d0 | v1 rd1 d1 | r0 r1 | we wreg wdata | stall (cumulative, counter build)
        vecs[0]  = '{1, 5'd5, 64'hDEADBEEF_00000001, 0, 5'd0, 64'h0,
                     1, 0, 1, 5'd5, 64'hDEADBEEF_00000001, 16'd0};
        vecs[1]  = '{0, 5'd0, 64'h0, 0, 5'd0, 64'h0,
                     0, 0, 0, 5'd5, 64'hDEADBEEF_00000001, 16'd0};
        vecs[2]  = '{1, 5'd1, 64'h11, 1, 5'd2, 64'h22, 0, 1, 1, 5'd2, 64'h22, 16'd1};
        vecs[3]  = '{1, 5'd1, 64'h11, 1, 5'd2, 64'h22, 1, 0, 1, 5'd1, 64'h11, 16'd2};
        vecs[4]  = '{1, 5'd1, 64'h11, 1, 5'd2, 64'h22, 0, 1, 1, 5'd2, 64'h22, 16'd3};
        vecs[5]  = '{1, 5'd1, 64'h11, 1, 5'd2, 64'h22, 1, 0, 1, 5'd1, 64'h11, 16'd4};
        vecs[6]  = '{0, 5'd0, 64'h0, 1, 5'd2, 64'h22, 0, 1, 1, 5'd2, 64'h22, 16'd4};
        vecs[7]  = '{0, 5'd0, 64'h0, 1, 5'd0, 64'hFFFF, 0, 1, 0, 5'd0, 64'hFFFF, 16'd4};
        vecs[8]  = '{1, 5'd0, 64'h5, 0, 5'd0, 64'h0, 1, 0, 0, 5'd0, 64'h5, 16'd4};
        vecs[9]  = '{0, 5'd0, 64'h0, 1, 5'd31, 64'hA5A5A5A5_5A5A5A5A,
                     0, 1, 1, 5'd31, 64'hA5A5A5A5_5A5A5A5A, 16'd4};
        vecs[10] = '{1, 5'd3, 64'h33, 1, 5'd4, 64'h44, 1, 0, 1, 5'd3, 64'h33, 16'd5};
        vecs[11] = '{0, 5'd0, 64'h0, 1, 5'd4, 64'h44, 0, 1, 1, 5'd4, 64'h44, 16'd5};
        vecs[12] = '{0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 0, 0, 5'd4, 64'h44, 16'd5};

        // Reset state, with a request pending to prove readies stay low.
        reset = 1'b0; init_req = 1'b0;
        v0 = 1'b1; rd0 = 5'd9; d0 = 64'h99; v1 = 1'b1; rd1 = 5'd10; d1 = 64'hAA;
        #3;
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_reg", 64'(wreg), 64'd0);
        chk("rst_data", wdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_r0", 64'(r0), 64'd0);
        chk("rst_r1", 64'(r1), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Power-on sweep: 32 zero writes to registers 0..31.
        for (int i = 0; i < 32; i++) begin
            step();
            chk("sweep_we", 64'(we), 64'd1);
            chk("sweep_reg", 64'(wreg), 64'(i));
            chk("sweep_data", wdata, 64'd0);
            chk("sweep_busy", 64'(busy), (i == 31) ? 64'd0 : 64'd1);
            chk("sweep_rdy", 64'({r0, r1}), 64'd0);
        end

        // RUN-mode vectors.
        for (int i = 0; i < 13; i++) begin
            v0 = vecs[i].v0; rd0 = vecs[i].rd0; d0 = vecs[i].d0;
            v1 = vecs[i].v1; rd1 = vecs[i].rd1; d1 = vecs[i].d1;
            #1;
            chk($sformatf("vec%0d_r0", i), 64'(r0), 64'(vecs[i].r0));
            chk($sformatf("vec%0d_r1", i), 64'(r1), 64'(vecs[i].r1));
            step();
            chk($sformatf("vec%0d_we", i), 64'(we), 64'(vecs[i].we));
            chk($sformatf("vec%0d_reg", i), 64'(wreg), 64'(vecs[i].wreg));
            chk($sformatf("vec%0d_data", i), wdata, vecs[i].wdata);
            chk($sformatf("vec%0d_stall", i), 64'(stall), 64'(exp_stall(vecs[i].stall)));
        end

        // init_req while req0 waits: no grant, full sweep, then req0 on first RUN cycle.
        v0 = 1'b1; rd0 = 5'd7; d0 = 64'h77; init_req = 1'b1;
        #1;
        chk("ireq_r0", 64'(r0), 64'd0);
        step();
        init_req = 1'b0;
        chk("ireq_we", 64'(we), 64'd0);
        chk("ireq_busy", 64'(busy), 64'd1);
        chk("ireq_stall", 64'(stall), 64'd0);
        for (int i = 0; i < 32; i++) begin
            chk("isweep_r0", 64'(r0), 64'd0);
            step();
            chk("isweep_reg", 64'(wreg), 64'(i));
            chk("isweep_we", 64'(we), 64'd1);
            chk("isweep_data", wdata, 64'd0);
        end
        chk("irun_r0", 64'(r0), 64'd1);
        chk("irun_busy", 64'(busy), 64'd0);
        step();
        chk("irun_we", 64'(we), 64'd1);
        chk("irun_reg", 64'(wreg), 64'd7);
        chk("irun_data", wdata, 64'h77);

        // Ten contended cycles: req0 went last, so req1 leads and grants alternate.
        v0 = 1'b1; rd0 = 5'd8; d0 = 64'h88; v1 = 1'b1; rd1 = 5'd9; d1 = 64'h99;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("cont_r0", 64'(r0), (k % 2 == 1) ? 64'd1 : 64'd0);
            chk("cont_r1", 64'(r1), (k % 2 == 0) ? 64'd1 : 64'd0);
            step();
            chk("cont_reg", 64'(wreg), (k % 2 == 0) ? 64'd9 : 64'd8);
        end
        chk("stall10", 64'(stall), 64'(exp_stall(10)));
        v0 = 1'b0;
        #1;
        chk("drain_r1", 64'(r1), 64'd1);
        step();
        chk("drain_reg", 64'(wreg), 64'd9);
        chk("drain_stall", 64'(stall), 64'(exp_stall(10)));
        v1 = 1'b0;

        // Reset in the middle of a sweep.
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        chk("clr_stall", 64'(stall), 64'd0);
        step();
        step();
        chk("mid_reg", 64'(wreg), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_we", 64'(we), 64'd0);
        chk("midrst_reg", 64'(wreg), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd1);
        chk("midrst_stall", 64'(stall), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        step();
        chk("restart_we", 64'(we), 64'd1);
        chk("restart_reg", 64'(wreg), 64'd0);
        step();
        chk("restart_reg1", 64'(wreg), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
